// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake and UART-core-side launch signals of the round-robin TX scheduler.
// slave: the scheduler's view. master: the requesters plus the UART core.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         data_out;
  logic                      s_ticks;
  logic                      tx_done_tick;

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_done_tick,
    output req_ready,
    output tx_start,
    output data_out,
    output s_ticks
  );

  modport master (
    output req_valid,
    output req_data,
    output tx_done_tick,
    input  req_ready,
    input  tx_start,
    input  data_out,
    input  s_ticks
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with a free-running baud sub-tick generator and a frame-completion watchdog.
module uart_tx_sched #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = 8,
  parameter  int DIVISOR     = 54,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          enable,
  input  logic          err_clr,
  uart_tx_sched_if.slave bus,
  output logic [GW-1:0] grant_id,
  output logic          busy,
  output logic          timeout_err,
  output logic [1:0]    state_dbg
);

  // Handshake: requester i holds req_valid[i] and its byte stable until it sees
  // req_ready[i] high for one cycle; the byte is captured at the end of that cycle.

  localparam int TW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_LAUNCH = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      sel_idx;
  logic               sel_found;
  logic [WDW-1:0]     wd_cnt;
  logic               wd_expire;
  logic [TW-1:0]      tick_cnt;
  logic               s_ticks_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               tx_start_q;
  logic [DATA_W-1:0]  data_q;

  assign bus.req_ready = req_ready_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.data_out  = data_q;
  assign bus.s_ticks   = s_ticks_q;
  assign state_dbg     = state;

  // s_ticks is registered one count early so it is high exactly while tick_cnt == DIVISOR-1.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt  <= '0;
      s_ticks_q <= 1'b0;
    end else begin
      tick_cnt  <= (tick_cnt == TW'(DIVISOR - 1)) ? '0 : tick_cnt + 1'b1;
      s_ticks_q <= (tick_cnt == TW'(DIVISOR - 2));
    end
  end

  // Rotating priority: scan last_grant+1, last_grant+2, ... wrapping at NUM_REQ.
  always_comb begin
    int idx;
    sel_idx   = '0;
    sel_found = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && bus.req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(idx);
      end
    end
  end

  // Counter reaches TIMEOUT_CYC-1 on the edge that ends the current WAIT cycle.
  assign wd_expire = (wd_cnt == WDW'(TIMEOUT_CYC - 2));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable && sel_found) state_nxt = ST_GRANT;
      ST_GRANT:  state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (bus.tx_done_tick || wd_expire) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      last_grant  <= GW'(NUM_REQ - 1);
      grant_id    <= '0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      data_q      <= '0;
      wd_cnt      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_GRANT) begin
            grant_id    <= sel_idx;
            req_ready_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
          end
        end
        ST_GRANT: begin
          data_q     <= bus.req_data[grant_id*DATA_W +: DATA_W];
          last_grant <= grant_id;
          tx_start_q <= 1'b1;
        end
        ST_LAUNCH: wd_cnt <= '0;
        ST_WAIT:   wd_cnt <= wd_cnt + 1'b1;
        default: ;
      endcase
      // A completing frame masks a coincident timeout; a new error outranks err_clr.
      if (state == ST_WAIT && wd_expire && !bus.tx_done_tick)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a behavioural UART core answers each tx_start with
// tx_done_tick, and a queue of expected {grant_id, byte} pairs is checked at every launch.
module tb_uart_tx_sched;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int DIV = 5;
  localparam int TMO = 16;
  localparam int SBW = 2 + DW;

  logic       clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic       err_clr;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;
  logic [1:0] state_dbg;

  uart_tx_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_sched #(
    .NUM_REQ(NR), .DATA_W(DW), .DIVISOR(DIV), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .enable     (enable),
    .err_clr    (err_clr),
    .bus        (bus.slave),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err),
    .state_dbg  (state_dbg)
  );

  int             n_cmp = 0;
  int             n_err = 0;
  logic [SBW-1:0] exp_q[$];
  int             frame_cyc = 12;
  logic           uart_mute = 1'b0;
  logic           auto_drop = 1'b1;
  logic           no_ready_chk = 1'b0;
  int             tk;
  int             cyc = 0;
  int             start_cnt = 0;
  int             last_start = -1;
  int             last_gap = 0;
  logic [NR-1:0]  prev_ready = '0;
  logic           prev_start = 1'b0;

  // ---------------- clock / tick reference ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge Reset) begin
    if (Reset) tk <= 0;
    else       tk <= (tk == DIV - 1) ? 0 : tk + 1;
  end

  // ---------------- behavioural UART core ----------------
  initial begin
    bus.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (!Reset && bus.tx_start === 1'b1 && !uart_mute) begin
        for (int k = 0; k < frame_cyc; k++) begin
          @(negedge clk);
          if (Reset) break;
        end
        if (!Reset) begin
          bus.tx_done_tick = 1'b1;
          @(negedge clk);
          bus.tx_done_tick = 1'b0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SBW-1:0] sb(input int id, input int d);
    logic [1:0]    i2;
    logic [DW-1:0] d8;
    i2 = id[1:0];
    d8 = d[DW-1:0];
    return {i2, d8};
  endfunction

  // One clock cycle; observation happens at the falling edge.
  task automatic step();
    logic [SBW-1:0] e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!Reset) chk("s_ticks", 32'(bus.s_ticks), 32'(tk == DIV - 1));
    if (prev_ready !== '0) chk("ready_width", 32'(bus.req_ready & prev_ready), 0);
    if (prev_start) chk("start_width", 32'(bus.tx_start), 0);
    if (bus.req_ready !== '0) begin
      chk("ready_onehot", 32'($onehot(bus.req_ready)), 1);
      if (auto_drop) bus.req_valid = bus.req_valid & ~bus.req_ready;
    end
    if (no_ready_chk) chk("ready_while_disabled", 32'(bus.req_ready), 0);
    if (bus.tx_start === 1'b1) begin
      start_cnt++;
      if (last_start >= 0) last_gap = cyc - last_start;
      last_start = cyc;
      chk("sb_expected_start", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_grant_data", 32'({grant_id, bus.data_out}), 32'(e));
      end
    end
    prev_ready = bus.req_ready;
    prev_start = bus.tx_start;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(bus.req_valid === '0 && busy === 1'b0) && n < budget);
    chk(tag, 32'(bus.req_valid === '0 && busy === 1'b0), 1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tx_start !== 1'b1 && n < 20);
    chk(tag, 32'(bus.tx_start), 1);
  endtask

  task automatic wait_timeout(input string tag, output int k);
    k = 0;
    while (timeout_err !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk(tag, k, TMO);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int n_rdy;
    int n_st;
    int starts0;

    Reset = 1'b1;
    enable = 1'b1;
    err_clr = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_start", 32'(bus.tx_start), 0);
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_ticks", 32'(bus.s_ticks), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_state", 32'(state_dbg), 0);
    Reset = 1'b0;
    repeat (12) step();

    // Single requester 2, cycle-exact latency.
    bus.req_data[23:16] = 8'hA5;
    bus.req_valid = 4'b0100;
    exp_q.push_back(sb(2, 'hA5));
    chk("a_ready_n0", 32'(bus.req_ready), 0);
    chk("a_busy_n0", 32'(busy), 0);
    step();
    chk("a_ready_n1", 32'(bus.req_ready), 32'h4);
    chk("a_busy_n1", 32'(busy), 1);
    chk("a_grant_n1", 32'(grant_id), 2);
    step();
    chk("a_start_n2", 32'(bus.tx_start), 1);
    chk("a_data_n2", 32'(bus.data_out), 32'hA5);
    step();
    chk("a_wait_n3", 32'(state_dbg), 3);
    repeat (5) step();
    chk("a_data_held", 32'(bus.data_out), 32'hA5);
    run_until_idle("a_done", 100);
    chk("a_grant_kept", 32'(grant_id), 2);
    chk("a_data_kept", 32'(bus.data_out), 32'hA5);

    // Enable dropped mid-frame with requesters 1 and 3 pending.
    bus.req_data[15:8] = 8'h52;
    bus.req_valid = 4'b0010;
    exp_q.push_back(sb(1, 'h52));
    wait_start("e_start");
    step();
    step();
    enable = 1'b0;
    bus.req_data[15:8] = 8'h53;
    bus.req_data[31:24] = 8'h73;
    bus.req_valid = 4'b1010;
    no_ready_chk = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 50) begin
      step();
      k++;
    end
    chk("e_frame_done", 32'(busy), 0);
    repeat (10) step();
    chk("e_idle_disabled", 32'(state_dbg), 0);
    chk("e_valid_pending", 32'(bus.req_valid), 32'hA);
    no_ready_chk = 1'b0;
    exp_q.push_back(sb(3, 'h73));
    exp_q.push_back(sb(1, 'h53));
    enable = 1'b1;
    step();
    chk("e_req3_first", 32'(bus.req_ready), 32'h8);
    run_until_idle("e_drain", 200);

    // Watchdog: no done, then clear and recover.
    uart_mute = 1'b1;
    bus.req_data[7:0] = 8'h3C;
    bus.req_valid = 4'b0001;
    exp_q.push_back(sb(0, 'h3C));
    wait_start("d_start");
    wait_timeout("d_timeout_delay", k);
    chk("d_idle", 32'(state_dbg), 0);
    chk("d_busy", 32'(busy), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("d_err_cleared", 32'(timeout_err), 0);

    // Timeout while err_clr held: setting outranks clearing.
    bus.req_data[7:0] = 8'h3D;
    bus.req_valid = 4'b0001;
    exp_q.push_back(sb(0, 'h3D));
    wait_start("d2_start");
    err_clr = 1'b1;
    wait_timeout("d2_timeout_delay", k);
    step();
    chk("d2_cleared_after", 32'(timeout_err), 0);
    err_clr = 1'b0;

    // Done in the very cycle the watchdog expires: no error.
    uart_mute = 1'b0;
    frame_cyc = TMO - 1;
    bus.req_data[7:0] = 8'h3E;
    bus.req_valid = 4'b0001;
    exp_q.push_back(sb(0, 'h3E));
    run_until_idle("d3_done", 100);
    chk("d3_done_wins", 32'(timeout_err), 0);
    frame_cyc = 12;

    // Reset in the middle of a frame.
    bus.req_data[23:16] = 8'h2F;
    bus.req_valid = 4'b0100;
    exp_q.push_back(sb(2, 'h2F));
    wait_start("f_start");
    step();
    step();
    Reset = 1'b1;
    #1;
    chk("f_rst_ready", 32'(bus.req_ready), 0);
    chk("f_rst_start", 32'(bus.tx_start), 0);
    chk("f_rst_data", 32'(bus.data_out), 0);
    chk("f_rst_grant", 32'(grant_id), 0);
    chk("f_rst_busy", 32'(busy), 0);
    chk("f_rst_state", 32'(state_dbg), 0);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    prev_ready = '0;
    prev_start = 1'b0;
    starts0 = start_cnt;
    repeat (20) step();
    chk("f_no_spurious_start", start_cnt - starts0, 0);

    // All four continuously valid: order restarts at requester 0.
    auto_drop = 1'b0;
    last_start = -1;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'hF;
    exp_q.push_back(sb(0, 'h10));
    exp_q.push_back(sb(1, 'h11));
    exp_q.push_back(sb(2, 'h12));
    exp_q.push_back(sb(3, 'h13));
    exp_q.push_back(sb(0, 'h10));
    n_rdy = 0;
    n_st = 0;
    for (int i = 0; i < 400 && n_rdy < 5; i++) begin
      step();
      if (bus.tx_start === 1'b1) begin
        n_st++;
        // done lands frame_cyc cycles after a start; IDLE, GRANT, LAUNCH follow.
        if (n_st > 1) chk("rr_start_gap", last_gap, frame_cyc + 3);
      end
      if (bus.req_ready !== '0) begin
        chk("rr_order", 32'(bus.req_ready), 32'(1) << (n_rdy % 4));
        n_rdy++;
      end
    end
    chk("rr_five_grants", n_rdy, 5);
    bus.req_valid = '0;
    auto_drop = 1'b1;
    run_until_idle("rr_drain", 200);
    repeat (5) step();

    chk("sb_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
